// File: rtl/spectrum_pkg.sv
// Shared types and helpers for the spectrum bar-table writer.
// Contents:
//   NUM_BINS_DEFAULT  default number of bins per frame and the table depth
//   HEIGHT_W          width of a bar height, in bits
//   CPLX_W            width of one complex bin word (re and im, 18 bits each)
//   height_t          unsigned bar height
//   bin_word_t        one table word: [35:18] = height, [17:0] = 0
//   comp_t            signed real or imaginary component
//   abs_sat()         absolute value that saturates the most negative input
package spectrum_pkg;

  localparam int unsigned NUM_BINS_DEFAULT = 16;
  localparam int unsigned HEIGHT_W         = 18;
  localparam int unsigned CPLX_W           = 36;

  typedef logic [HEIGHT_W-1:0]        height_t;
  typedef logic [CPLX_W-1:0]          bin_word_t;
  typedef logic signed [CPLX_W/2-1:0] comp_t;

  // The negation of the most negative value does not fit in 18 bits,
  // so that one input maps to the largest positive value instead.
  function automatic height_t abs_sat(input comp_t x);
    if (!x[CPLX_W/2-1]) begin
      return height_t'(x);
    end
    if (x == {1'b1, {(CPLX_W/2-1){1'b0}}}) begin
      return {1'b0, {(HEIGHT_W-1){1'b1}}};
    end
    return height_t'(-x);
  endfunction

endpackage

// File: rtl/spectrum_mag_pipe.sv
// Two-stage magnitude pipe: converts one complex bin into a bar height.
//   Stage 1 registers |re| and |im| (saturating abs).
//   Stage 2 registers (|re|+|im|) >> MAG_SHIFT, clamped to MAX_HEIGHT.
// A valid bit, the bin index and the last flag travel alongside the data.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drop everything currently in flight
//   valid_i         a bin enters the pipe this cycle
//   re_i, im_i      signed components of the bin
//   idx_i, last_i   bin index and end-of-frame flag carried along
//   valid_o         height_o / idx_o / last_o hold a result this cycle
//   idx_o, last_o   index and flag of the result
//   height_o        clamped bar height
module spectrum_mag_pipe
  import spectrum_pkg::*;
#(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned MAG_SHIFT  = 4,
  parameter int unsigned MAX_HEIGHT = 480
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  input  comp_t            re_i,
  input  comp_t            im_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o,
  output height_t          height_o
);

  typedef logic [HEIGHT_W:0] sum_t;

  logic             s1_valid_q, s1_last_q;
  logic [IDX_W-1:0] s1_idx_q;
  height_t          s1_re_q, s1_im_q;

  logic             s2_valid_q, s2_last_q;
  logic [IDX_W-1:0] s2_idx_q;
  height_t          s2_height_q;

  sum_t    sum, shifted;
  height_t height_d;

  always_comb begin
    sum      = {1'b0, s1_re_q} + {1'b0, s1_im_q};
    shifted  = sum >> MAG_SHIFT;
    height_d = (shifted > sum_t'(MAX_HEIGHT)) ? height_t'(MAX_HEIGHT)
                                              : shifted[HEIGHT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_idx_q    <= '0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_idx_q    <= '0;
      s2_height_q <= '0;
    end else begin
      s1_valid_q  <= valid_i & ~flush_i;
      s1_last_q   <= last_i;
      s1_idx_q    <= idx_i;
      s1_re_q     <= abs_sat(re_i);
      s1_im_q     <= abs_sat(im_i);
      s2_valid_q  <= s1_valid_q & ~flush_i;
      s2_last_q   <= s1_last_q;
      s2_idx_q    <= s1_idx_q;
      s2_height_q <= height_d;
    end
  end

  assign valid_o  = s2_valid_q;
  assign idx_o    = s2_idx_q;
  assign last_o   = s2_last_q;
  assign height_o = s2_height_q;

endmodule

// File: rtl/spectrum_bin_writer.sv
// Producer side of the bar table read by the graphics controller.
// Accepts a valid/ready stream of complex FFT bins (0..NUM_BINS-1 in order),
// converts each to a bar height, collects them in a back buffer and publishes
// a complete table to the front register only on a frame_start pulse.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         upstream bin valid
//   in_ready         bin can be accepted (low while a table awaits publication)
//   in_re, in_im     signed bin components
//   in_last          asserted with the final bin of a frame
//   frame_start      one-cycle pulse at the start of vertical blanking
//   frequencies      published table; each word [35:18] = height, [17:0] = 0
//   swapped          one-cycle pulse after the front table is updated
//   seq_err          one-cycle pulse after a framing error discarded a frame
module spectrum_bin_writer
  import spectrum_pkg::*;
#(
  parameter int unsigned NUM_BINS   = NUM_BINS_DEFAULT,
  parameter int unsigned MAG_SHIFT  = 4,
  parameter int unsigned MAX_HEIGHT = 480
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  comp_t                      in_re,
  input  comp_t                      in_im,
  input  logic                       in_last,
  input  logic                       frame_start,
  output bin_word_t [NUM_BINS-1:0]   frequencies,
  output logic                       swapped,
  output logic                       seq_err
);

  localparam int unsigned IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  height_t [NUM_BINS-1:0]   back_q, back_d;
  bin_word_t [NUM_BINS-1:0] freq_q, freq_d;
  logic                     swapped_q, seq_err_q;

  logic             accept, last_bin, frame_err;
  logic             p_valid, p_last, wr_en, commit, swap;
  logic [IDX_W-1:0] p_idx;
  height_t          p_height;

  // Ready is forced low while reset is asserted, not just after it.
  assign in_ready  = rst_n & ~pending_q;
  assign accept    = in_valid & in_ready;
  assign last_bin  = (cnt_q == IDX_W'(NUM_BINS - 1));
  // in_last and the final counter position must coincide.
  assign frame_err = accept & (in_last != last_bin);

  spectrum_mag_pipe #(
    .IDX_W      (IDX_W),
    .MAG_SHIFT  (MAG_SHIFT),
    .MAX_HEIGHT (MAX_HEIGHT)
  ) u_mag_pipe (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .flush_i  (frame_err),
    .valid_i  (accept & ~frame_err),
    .re_i     (in_re),
    .im_i     (in_im),
    .idx_i    (cnt_q),
    .last_i   (in_last),
    .valid_o  (p_valid),
    .idx_o    (p_idx),
    .last_o   (p_last),
    .height_o (p_height)
  );

  // A bin leaving the pipe in an error cycle belongs to the discarded frame.
  assign wr_en  = p_valid & ~frame_err;
  assign commit = wr_en & p_last;
  assign swap   = frame_start & (pending_q | commit);

  always_comb begin
    back_d    = back_q;
    freq_d    = freq_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;

    if (wr_en) begin
      back_d[p_idx] = p_height;
    end

    // Publishing from back_d lets a commit and a swap share one cycle.
    if (swap) begin
      for (int unsigned i = 0; i < NUM_BINS; i++) begin
        freq_d[i] = {back_d[i], {HEIGHT_W{1'b0}}};
      end
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end

    if (frame_err || (accept && last_bin)) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      back_q    <= '0;
      freq_q    <= '0;
      swapped_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      back_q    <= back_d;
      freq_q    <= freq_d;
      swapped_q <= swap;
      seq_err_q <= frame_err;
    end
  end

  assign frequencies = freq_q;
  assign swapped     = swapped_q;
  assign seq_err     = seq_err_q;

endmodule
